// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the read-domain FIFO packer.
//   DEF_DSIZE   : default FIFO word width
//   DEF_RATIO   : default number of FIFO words per output beat
//   KEEP_W      : m_keep width for the default configuration
//   lane_cnt_w  : width of a counter that can hold 0..ratio inclusive
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DSIZE = 8;
    localparam int DEF_RATIO = 4;
    localparam int KEEP_W    = DEF_RATIO;

    // One extra bit over clog2 so the counter can represent "ratio" itself.
    function automatic int lane_cnt_w(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
// Output beat stream of the FIFO read packer.
//   m_valid : beat valid (driven by master)
//   m_ready : sink ready (driven by slave)
//   m_data  : packed beat, lane i = m_data[i*DSIZE +: DSIZE]
//   m_keep  : per-lane valid mask
// Handshake: a beat transfers on a clock edge where m_valid & m_ready. Once
// m_valid is high it stays high, and m_data/m_keep stay stable, until that
// transfer happens; m_ready may change freely and never depends on m_valid.
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int RATIO = DEF_RATIO
);

    logic                   m_valid;
    logic                   m_ready;
    logic [DSIZE*RATIO-1:0] m_data;
    logic [RATIO-1:0]       m_keep;

    modport master (
        output m_valid,
        output m_data,
        output m_keep,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_keep,
        output m_ready
    );

endinterface

// File: rtl/fifo_rd_skid2.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid2
// Two-entry valid/ready buffer. The producer pushes without a ready signal;
// the upstream pop controller guarantees a push never arrives while both
// entries are occupied and no pop happens in the same cycle.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : push a word this cycle
//   in_data    : word to push
//   out_valid  : head entry valid (buffer not empty)
//   out_ready  : consumer accepts head this cycle
//   out_data   : head entry, held stable until popped
//   count      : number of occupied entries (0..2)
// -----------------------------------------------------------------------------
module fifo_rd_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q,  cnt_d;
    logic         pop;

    assign pop = (cnt_q != 2'd0) && out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({in_valid, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = in_data;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    tail_d = in_data;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign count     = cnt_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Pops DSIZE-bit words from the read side of a dual-clock FIFO (data returns
// one cycle after the pop), packs RATIO consecutive words into one beat with
// the first word in lane 0, and presents beats on a valid/ready stream through
// a 2-entry buffer. Output back-pressure throttles pops; no word is dropped.
//   rclk     : read-domain clock
//   rrst     : synchronous active-high reset
//   rinc     : pop request to the FIFO
//   rdata    : FIFO read data, valid the cycle after an accepted pop
//   rempty   : FIFO empty flag
//   m_if     : output beat stream (master modport)
//   lane_cnt : words currently held in the partial pack register (debug)
// Optional build macro FIFO_RD_PACK_FLUSH_EN: when defined, a partial beat is
// flushed (with a partial m_keep) after FLUSH_CYCLES idle cycles. When not
// defined a partial beat waits for more words and m_keep is always all ones.
// -----------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE        = DEF_DSIZE,
    parameter int RATIO        = DEF_RATIO,
    parameter int FLUSH_CYCLES = 16,
    localparam int LCW         = lane_cnt_w(RATIO),
    localparam int BW          = DSIZE * RATIO
) (
    input  logic             rclk,
    input  logic             rrst,
    output logic             rinc,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    fifo_rd_packer_if.master m_if,
    output logic [LCW-1:0]   lane_cnt
);

    logic [LCW-1:0]  lane_cnt_q, lane_cnt_d;
    logic            inflight_q, inflight_d;
    logic [BW-1:0]   pack_q,     pack_d;

    logic [1:0]      buf_cnt;
    logic            push_valid;
    logic [BW-1:0]   push_data;
    logic [RATIO-1:0] push_keep;
    logic [BW+RATIO-1:0] buf_out;

    logic [LCW:0]    fill;
    logic            allow;
    logic            pop_acc;
    logic [BW-1:0]   beat;
    logic            last_lane;

    // ---------------- pop controller ----------------
    // With one buffered beat, only pop while the word in hand plus the one in
    // flight cannot complete a beat before the buffer has room again.
    assign fill  = {1'b0, lane_cnt_q} + {{LCW{1'b0}}, inflight_q};
    assign allow = (buf_cnt == 2'd0) ||
                   ((buf_cnt == 2'd1) && (fill < (LCW+1)'(RATIO - 1)));

    assign rinc    = ~rempty & ~rrst & allow;
    assign pop_acc = rinc & ~rempty;

    // ---------------- packing ----------------
    assign last_lane = inflight_q && (lane_cnt_q == LCW'(RATIO - 1));

    always_comb begin
        beat = pack_q;
        if (inflight_q) begin
            beat[int'(lane_cnt_q) * DSIZE +: DSIZE] = rdata;
        end
    end

`ifdef FIFO_RD_PACK_FLUSH_EN
    localparam int IW = $clog2(FLUSH_CYCLES + 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          flush_go;

    // The counter saturates at FLUSH_CYCLES so a flush blocked by a full
    // buffer fires as soon as an entry frees up.
    assign flush_go = (idle_q == IW'(FLUSH_CYCLES)) && !inflight_q &&
                      (lane_cnt_q != '0) && (buf_cnt != 2'd2);

    always_comb begin
        idle_d = idle_q;
        if (pop_acc || flush_go) begin
            idle_d = '0;
        end else if ((lane_cnt_q != '0) && !inflight_q &&
                     (idle_q != IW'(FLUSH_CYCLES))) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic flush_go;
    assign flush_go = 1'b0;
`endif

    always_comb begin
        pack_d     = beat;
        lane_cnt_d = lane_cnt_q + {{(LCW-1){1'b0}}, inflight_q};
        inflight_d = pop_acc;
        push_valid = 1'b0;
        push_data  = beat;
        push_keep  = '1;
        if (last_lane) begin
            push_valid = 1'b1;
            pack_d     = '0;
            lane_cnt_d = '0;
        end else if (flush_go) begin
            // Flush never coincides with a capture (it requires inflight=0),
            // so pack_q already holds exactly lane_cnt words, rest zero.
            push_valid = 1'b1;
            push_data  = pack_q;
            for (int i = 0; i < RATIO; i++) begin
                push_keep[i] = (i < int'(lane_cnt_q));
            end
            pack_d     = '0;
            lane_cnt_d = '0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            lane_cnt_q <= '0;
            inflight_q <= 1'b0;
            pack_q     <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            inflight_q <= inflight_d;
            pack_q     <= pack_d;
        end
    end

    // ---------------- output buffer ----------------
    fifo_rd_skid2 #(
        .W (BW + RATIO)
    ) u_buf (
        .clk       (rclk),
        .rst       (rrst),
        .in_valid  (push_valid),
        .in_data   ({push_keep, push_data}),
        .out_valid (m_if.m_valid),
        .out_ready (m_if.m_ready),
        .out_data  (buf_out),
        .count     (buf_cnt)
    );

    assign m_if.m_keep = buf_out[BW +: RATIO];
    assign m_if.m_data = buf_out[BW-1:0];
    assign lane_cnt    = lane_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Bench for fifo_rd_packer. A FIFO model returns popped words one cycle after
// the pop; every accepted word enters an ordered expected list, and each beat
// that leaves the stream must equal the next RATIO words (or, for a flushed
// partial beat, all words still pending) with the matching keep mask. Reset
// discards every pending word.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int DSIZE        = 8;
    localparam int RATIO        = 4;
    localparam int FLUSH_CYCLES = 16;
    localparam int LCW          = lane_cnt_w(RATIO);
    localparam int BW           = DSIZE * RATIO;

    logic             rclk = 1'b0;
    logic             rrst;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic [LCW-1:0]   lane_cnt;

    fifo_rd_packer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) m_if ();

    fifo_rd_packer #(
        .DSIZE        (DSIZE),
        .RATIO        (RATIO),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rinc     (rinc),
        .rdata    (rdata),
        .rempty   (rempty),
        .m_if     (m_if),
        .lane_cnt (lane_cnt)
    );

    // ---------------- clock ----------------
    always #5 rclk = ~rclk;

    // ---------------- bench state ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [DSIZE-1:0] src_q[$];   // words the FIFO model still holds
    logic [DSIZE-1:0] exp_q[$];   // accepted words not yet seen in a beat

    bit   gap_en     = 0;
    bit   gap_phase  = 0;
    int   ready_mode = 1;         // 0 = low, 1 = high, 2 = random
    int   low_run    = 0;
    bit   rst_req    = 0;
    bit   prev_rst   = 0;
    bit   acc_prev   = 0;
    logic [DSIZE-1:0] word_prev = '0;
    int   cyc        = 0;
    int   beats_seen = 0;
    int   first_valid_cyc = -1;
    int   last_pop_cyc    = 0;
    bit   hold_valid = 0;
    logic [BW+RATIO-1:0] hold_val = '0;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- one clock cycle: drive, monitor, model ----------------
    task automatic step();
        logic [DSIZE-1:0] w;
        logic [BW-1:0]    ed;
        logic [RATIO-1:0] ek;
        int               n;
        bit               acc;
        w = '0;
        @(negedge rclk);
        // FIFO model: data of last cycle's pop, otherwise garbage.
        rdata     = acc_prev ? word_prev : DSIZE'($urandom);
        rrst      = rst_req;
        gap_phase = ~gap_phase;
        rempty    = (src_q.size() == 0) || (gap_en && gap_phase);
        case (ready_mode)
            0:       m_if.m_ready = 1'b0;
            1:       m_if.m_ready = 1'b1;
            default: begin
                if (low_run >= 3) m_if.m_ready = 1'b1;
                else              m_if.m_ready = 1'($urandom_range(0, 1));
                low_run = m_if.m_ready ? 0 : low_run + 1;
            end
        endcase
        #1;

        if (rrst) check_eq("rinc_in_reset", rinc, 0);
        if (prev_rst) begin
            check_eq("rst_m_valid",  m_if.m_valid, 0);
            check_eq("rst_m_keep",   m_if.m_keep, 0);
            check_eq("rst_m_data",   m_if.m_data, 0);
            check_eq("rst_lane_cnt", lane_cnt, 0);
        end else if (hold_valid) begin
            check_eq("hold_valid", m_if.m_valid, 1);
            check_eq("hold_stable", {m_if.m_keep, m_if.m_data}, hold_val);
        end

        if (dut.buf_cnt == 2'd2) check_eq("rinc_buf_full", rinc, 0);

        if (!rrst && m_if.m_valid && m_if.m_ready) begin
            n  = (exp_q.size() < RATIO) ? exp_q.size() : RATIO;
            ed = '0;
            ek = '0;
            for (int i = 0; i < n; i++) begin
                ed[i*DSIZE +: DSIZE] = exp_q.pop_front();
                ek[i] = 1'b1;
            end
            check_eq("beat_data", m_if.m_data, ed);
            check_eq("beat_keep", m_if.m_keep, ek);
            beats_seen++;
        end

        hold_valid = m_if.m_valid && !m_if.m_ready && !rrst;
        hold_val   = {m_if.m_keep, m_if.m_data};
        if (m_if.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        acc = rinc && !rempty;
        if (acc) begin
            w = src_q.pop_front();
            exp_q.push_back(w);
            last_pop_cyc = cyc;
        end
        if (rrst) exp_q.delete();
        acc_prev  = acc;
        word_prev = w;
        prev_rst  = rrst;
        cyc++;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            step();
            done = (src_q.size() == 0) && (exp_q.size() == 0) && !m_if.m_valid;
        end
        check_eq("drain_done", done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rrst         = 1'b1;
        rdata        = '0;
        rempty       = 1'b1;
        m_if.m_ready = 1'b0;

        // Reset with a non-empty FIFO, then the basic pack.
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_req = 1;
        repeat (3) step();
        rst_req = 0;
        ready_mode = 1;
        beats_seen = 0;
        first_valid_cyc = -1;
        drain();
        check_eq("basic_beats", beats_seen, 1);
        check_eq("basic_latency", first_valid_cyc - last_pop_cyc, 2);

        // Back-pressure: pops stop, pack register never reaches a full beat.
        for (int i = 0; i < 16; i++) src_q.push_back(DSIZE'(i));
        ready_mode = 0;
        beats_seen = 0;
        repeat (14) step();
        check_eq("bp_rinc_low", rinc, 0);
        check_eq("bp_lane_le3", lane_cnt <= LCW'(3), 1);
        check_eq("bp_m_valid",  m_if.m_valid, 1);
        ready_mode = 1;
        drain();
        check_eq("bp_beats", beats_seen, 4);

        // Empty gaps with random back-pressure.
        for (int i = 0; i < 200; i++) src_q.push_back(DSIZE'($urandom));
        gap_en = 1;
        ready_mode = 2;
        beats_seen = 0;
        drain();
        check_eq("gap_beats", beats_seen, 50);
        gap_en = 0;
        ready_mode = 1;

        // Reset while the second word is in flight.
        src_q = '{8'hA0, 8'hA1};
        beats_seen = 0;
        for (int k = 0; k < 10 && src_q.size() > 0; k++) step();
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        repeat (10) step();
        check_eq("rst_mid_lane", lane_cnt, 0);
        check_eq("rst_mid_nobeat", beats_seen, 0);
        src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        drain();
        check_eq("rst_mid_clean_beat", beats_seen, 1);

        // Partial beat followed by an empty FIFO.
        src_q = '{8'hAA, 8'hBB};
        beats_seen = 0;
        first_valid_cyc = -1;
`ifdef FIFO_RD_PACK_FLUSH_EN
        for (int k = 0; k < 60 && beats_seen == 0; k++) step();
        check_eq("flush_beats", beats_seen, 1);
        check_eq("flush_delay_ok",
                 (first_valid_cyc - last_pop_cyc >= FLUSH_CYCLES + 2) &&
                 (first_valid_cyc - last_pop_cyc <= FLUSH_CYCLES + 4), 1);
        check_eq("flush_lane_cnt", lane_cnt, 0);
`else
        repeat (100) step();
        check_eq("noflush_beats", beats_seen, 0);
        check_eq("noflush_lane_cnt", lane_cnt, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
